// File: rtl/bus_memory_responder.sv
// bus_memory_responder
//   Responder end of the core's two-phase select/enable bus, backed by a
//   word-addressed single-port register-array RAM. Each setup/access pair
//   moves one 32-bit word after a configurable number of wait states. Bus
//   protocol violations and out-of-window or misaligned accesses raise a
//   sticky error flag.
//
// Ports
//   clk     clock
//   rst     synchronous, active-high reset
//   addr    byte address, valid while select=1
//   select  transfer in progress (setup and access phases)
//   enable  access phase
//   write   write strobe, meaningful only while enable=1
//   wdata   write data, valid while enable=1
//   rdata   read data, valid only while ready=1, otherwise 0
//   ready   transfer completes this cycle
//   error   sticky protocol/decode error, cleared only by rst
//
// All outputs are registered. The ready pulse is computed at the end of an
// access cycle, so the earliest possible ready is the second access cycle;
// a wait count of 0 therefore behaves the same as a wait count of 1.
module bus_memory_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          MEM_WORDS  = 256,
  parameter int          READ_WAIT  = 2,
  parameter int          WRITE_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        select,
  input  logic        enable,
  input  logic        write,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        error
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [31:0] WIN_BYTES = 32'(MEM_WORDS) << 2;
  localparam logic [3:0]  R_WAIT    = 4'(READ_WAIT);
  localparam logic [3:0]  W_WAIT    = 4'(WRITE_WAIT);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;      // access cycles already counted, saturating
  logic [3:0]      wait_q, wait_d;    // wait count chosen in the first access cycle
  logic            wr_q, wr_d;        // direction chosen in the first access cycle
  logic [AW-1:0]   idx_q, idx_d;
  logic            hit_q, hit_d;
  logic            ready_q, ready_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            error_q, error_d;
  logic            mem_we;

  logic [31:0]     mem [MEM_WORDS];

  // Address decode of the live bus address; only used when it is latched.
  // The subtraction is plain 32-bit, so addresses below BASE_ADDR are
  // rejected by the explicit >= test rather than by wrap-around.
  logic [31:0] offset;
  logic        addr_hit;
  assign offset   = addr - BASE_ADDR;
  assign addr_hit = (addr >= BASE_ADDR) && (offset < WIN_BYTES) && (addr[1:0] == 2'b00);

  logic latch;     // capture addr decode this cycle
  logic fire;      // raise ready next cycle
  logic fire_wr;   // direction of the transfer that fires

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    hit_d   = hit_q;
    ready_d = 1'b0;
    rdata_d = '0;
    error_d = error_q;
    mem_we  = 1'b0;
    latch   = 1'b0;
    fire    = 1'b0;
    fire_wr = wr_q;

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          error_d = 1'b1;                 // access phase without a setup phase
        end else if (select) begin
          state_d = SETUP;
          latch   = 1'b1;
        end
      end

      SETUP: begin
        if (enable) begin
          if (select) begin
            // First access cycle: the direction seen now fixes the wait count.
            state_d = ACCESS;
            cnt_d   = '0;
            wr_d    = write;
            wait_d  = write ? W_WAIT : R_WAIT;
            fire_wr = write;
            fire    = (wait_d <= 4'd1);
          end else begin
            error_d = 1'b1;               // select dropped in the first access cycle
            state_d = IDLE;
          end
        end else if (select) begin
          latch = 1'b1;                   // extended setup, follow the new address
        end else begin
          state_d = IDLE;
        end
      end

      ACCESS: begin
        if (ready_q) begin
          // Completion cycle: the write lands at the edge ending it.
          mem_we  = hit_q && wr_q;
          state_d = DONE;
        end else if (select && enable) begin
          cnt_d = (cnt_q == 4'd15) ? cnt_q : cnt_q + 4'd1;
          // This is access cycle cnt_q+2; ready belongs in cycle wait+1.
          fire  = ({1'b0, cnt_q} + 5'd2 >= {1'b0, wait_q});
        end else begin
          error_d = 1'b1;                 // aborted before ready
          if (select) begin
            state_d = SETUP;
            latch   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end

      DONE: begin
        if (enable) begin
          error_d = 1'b1;                 // enable held past ready
        end else if (select) begin
          state_d = SETUP;                // back-to-back transfer
          latch   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (latch) begin
      idx_d = offset[AW+1:2];
      hit_d = addr_hit;
    end

    if (fire) begin
      ready_d = 1'b1;
      if (!hit_q) error_d = 1'b1;
      if (!fire_wr && hit_q) rdata_d = mem[idx_q];
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wait_q  <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      hit_q   <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  // NOTE: the storage array has no reset; clearing it would cost a write
  // port per word and the contents are defined only after being written.
  // A reset coinciding with the completion edge suppresses the write.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[idx_q] <= wdata;
  end

  assign ready = ready_q;
  assign rdata = rdata_q;
  assign error = error_q;

endmodule

// File: tb/tb_bus_memory_responder.sv
// Directed bench for bus_memory_responder. Stimulus pushes the expected read
// data and ready latency of each complete transfer into a queue; a monitor
// on the falling edge pops an entry for every ready pulse and compares.
module tb_bus_memory_responder;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          WORDS = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        select;
  logic        enable;
  logic        write;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        error;

  always #5 clk = ~clk;

  bus_memory_responder #(
    .BASE_ADDR (BASE),
    .MEM_WORDS (WORDS),
    .READ_WAIT (2),
    .WRITE_WAIT(1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .select(select),
    .enable(enable),
    .write (write),
    .wdata (wdata),
    .rdata (rdata),
    .ready (ready),
    .error (error)
  );

  typedef struct {
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   en_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: counts consecutive access cycles and checks every ready pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) en_cnt = 0;
      else if (select && enable) en_cnt++;
      else en_cnt = 0;
      if (!rst) begin
        if (ready === 1'b1) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_ready: ready=1, expected no completion at %0t", $time);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("rdata", rdata, e.rdata);
            check("latency", 32'(en_cnt), 32'(e.lat));
          end
        end else begin
          check("rdata_idle", rdata, 32'h0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    select = 1'b0;
    enable = 1'b0;
    write  = 1'b0;
  endtask

  task automatic rst_pulse();
    bus_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // idle -> setup -> access until ready, then release the bus.
  task automatic xfer(input logic [31:0] a, input logic wr, input logic [31:0] d,
                      input logic [31:0] exp_rd, input int lat);
    int n;
    sb.push_back('{exp_rd, lat});
    bus_idle();
    tick();
    select = 1'b1;
    addr   = a;
    tick();
    enable = 1'b1;
    write  = wr;
    wdata  = d;
    addr   = a ^ 32'h0000_0040;   // latched address must win
    n = 0;
    do begin
      tick();
      n++;
    end while (ready !== 1'b1 && n < 20);
    if (ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: no ready for addr 0x%08h after %0d cycles", a, n);
      void'(sb.pop_back());
    end
    tick();
    bus_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    addr  = '0;
    wdata = '0;
    bus_idle();
    repeat (3) tick();
    rst = 1'b0;

    // Reset state held while idle.
    repeat (5) begin
      tick();
      check("reset_ready", 32'(ready), 32'h0);
      check("reset_rdata", rdata, 32'h0);
      check("reset_error", 32'(error), 32'h0);
    end

    // Single write then read-back.
    xfer(BASE + 32'h10, 1'b1, 32'hCAFE_BABE, 32'h0, 2);
    xfer(BASE + 32'h10, 1'b0, 32'h0, 32'hCAFE_BABE, 3);

    // Cache-line style burst of writes, then reads.
    for (int i = 0; i < 8; i++)
      xfer(BASE + 32'(4 * i), 1'b1, 32'h100 + 32'(i), 32'h0, 2);
    for (int i = 0; i < 8; i++)
      xfer(BASE + 32'(4 * i), 1'b0, 32'h0, 32'h100 + 32'(i), 3);
    check("burst_error", 32'(error), 32'h0);

    // Out-of-window and misaligned accesses complete with zero data.
    xfer(BASE + 32'(WORDS * 4), 1'b0, 32'h0, 32'h0, 3);
    check("miss_error", 32'(error), 32'h1);
    xfer(BASE + 32'h2, 1'b0, 32'h0, 32'h0, 3);
    xfer(BASE + 32'h2, 1'b1, 32'hBAD0_BAD0, 32'h0, 2);
    xfer(BASE + 32'h0, 1'b0, 32'h0, 32'h100, 3);
    xfer(BASE + 32'h10, 1'b0, 32'h0, 32'h104, 3);
    check("miss_error_sticky", 32'(error), 32'h1);

    // Access phase with no setup phase.
    rst_pulse();
    check("clear_error", 32'(error), 32'h0);
    tick();
    select = 1'b1;
    enable = 1'b1;
    addr   = BASE + 32'h10;
    tick();
    bus_idle();
    tick();
    check("nosetup_error", 32'(error), 32'h1);

    // Write of 0x55 aborted by dropping select in the first access cycle.
    rst_pulse();
    tick();
    select = 1'b1;
    addr   = BASE + 32'h10;
    tick();
    select = 1'b0;
    enable = 1'b1;
    write  = 1'b1;
    wdata  = 32'h55;
    tick();
    bus_idle();
    tick();
    check("abort_error", 32'(error), 32'h1);
    xfer(BASE + 32'h10, 1'b0, 32'h0, 32'h104, 3);

    // Reset during the wait state of a write.
    rst_pulse();
    tick();
    select = 1'b1;
    addr   = BASE + 32'h0;
    tick();
    enable = 1'b1;
    write  = 1'b1;
    wdata  = 32'hDEAD_BEEF;
    rst    = 1'b1;
    tick();
    check("rst_mid_ready", 32'(ready), 32'h0);
    rst = 1'b0;
    bus_idle();
    tick();
    check("post_rst_ready", 32'(ready), 32'h0);
    xfer(BASE + 32'h0, 1'b0, 32'h0, 32'h100, 3);
    check("post_rst_error", 32'(error), 32'h0);

    bus_idle();
    repeat (3) tick();
    check("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
